// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and LED bit positions.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int LED_BORROW = 7;
    localparam int LED_DONE   = 14;
    localparam int LED_BUSY   = 15;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B, LSB first, one full-subtractor cell reused per step tick.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic        clk_pin,
    input  logic        rst_n_pin,
    input  logic [7:0]  sw_pin,
    input  logic        btn_pin,
    output logic [15:0] led_pin
);

    localparam int BW    = $clog2(WIDTH + 1);
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    state_t             state_q, state_d;
    logic               btn_meta_q, btn_sync_q, btn_prev_q;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d, diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               start, tick, cell_d, cell_bout;

    assign start = btn_sync_q & ~btn_prev_q;
    assign tick  = (tick_cnt_q == CNT_W'(STEP_DIV - 1));

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register plus all datapath/status flops; reset aborts any operation.
    always_ff @(posedge clk_pin or negedge rst_n_pin) begin
        if (!rst_n_pin) begin
            state_q    <= IDLE;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            tick_cnt_q <= '0;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            bitcnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_meta_q <= btn_pin;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            tick_cnt_q <= tick_cnt_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            bitcnt_q   <= bitcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (tick && bitcnt_q == BW'(WIDTH - 1)) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so the LEDs come straight off flops.
    always_comb begin
        busy_d = (state_d == LOAD) || (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        bitcnt_d   = bitcnt_q;
        if (state_q == LOAD) begin
            tick_cnt_d = '0;
            a_sr_d     = sw_pin[WIDTH-1:0];
            b_sr_d     = sw_pin[2*WIDTH-1:WIDTH];
            diff_d     = '0;
            borrow_d   = 1'b0;
            bitcnt_d   = '0;
        end else if (state_q == SHIFT) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) begin
                diff_d   = {cell_d, diff_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        led_pin             = '0;
        led_pin[WIDTH-1:0]  = diff_q;
        led_pin[LED_BORROW] = borrow_q;
        led_pin[LED_DONE]   = done_q;
        led_pin[LED_BUSY]   = busy_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive stimulus for serial_subtractor with a queue-based result scoreboard.
module tb_serial_subtractor;

    logic        clk_pin = 1'b0;
    logic        rst_n_pin = 1'b0;
    logic [7:0]  sw_pin = 8'h00;
    logic        btn_pin = 1'b0;
    logic [15:0] led_pin;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    serial_subtractor #(.WIDTH(4), .STEP_DIV(1)) dut (
        .clk_pin   (clk_pin),
        .rst_n_pin (rst_n_pin),
        .sw_pin    (sw_pin),
        .btn_pin   (btn_pin),
        .led_pin   (led_pin)
    );

    always #5 clk_pin = ~clk_pin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [7:0] sw);
        int a, b;
        a = int'(sw[3:0]);
        b = int'(sw[7:4]);
        return {(a < b) ? 1'b1 : 1'b0, 4'((a - b + 16) % 16)};
    endfunction

    // Press with btn high for `hold` samples; optional switch change and a re-press while busy.
    task automatic run_op(input logic [7:0] sw_v, input int hold, input bit chg,
                          input logic [7:0] sw_new, input bit repress, input string tag);
        int k;
        bit seen_busy;
        logic [4:0] exp;
        logic [15:0] led_done;
        @(negedge clk_pin);
        sw_pin = sw_v;
        exp_q.push_back(model(sw_v));
        btn_pin = 1'b1;
        k = 0;
        seen_busy = 1'b0;
        while (!(seen_busy && led_pin[14]) && k < 40) begin
            @(negedge clk_pin);
            k++;
            if (k == hold) btn_pin = 1'b0;
            if (repress && k == 1) btn_pin = 1'b0;
            if (repress && k == 3) btn_pin = 1'b1;
            if (chg && k == 5) sw_pin = sw_new;
            if (led_pin[15]) seen_busy = 1'b1;
            if (k == 6) check({tag, "_mid_busy_done"}, {30'd0, led_pin[15], led_pin[14]}, 32'h2);
        end
        check({tag, "_latency"}, k, 8);
        exp = exp_q.pop_front();
        check({tag, "_result"}, {led_pin[7], led_pin[3:0]}, exp);
        check({tag, "_flags"}, {led_pin[15:14], led_pin[13:8], led_pin[6:4]}, 11'b01_000000_000);
        led_done = led_pin;
        while (k < hold + 6) begin
            @(negedge clk_pin);
            k++;
            if (k == hold) btn_pin = 1'b0;
        end
        btn_pin = 1'b0;
        if (hold > 8 || repress) check({tag, "_no_restart"}, led_pin, led_done);
    endtask

    initial begin
        #3;
        check("reset_led", led_pin, 16'h0000);
        repeat (2) @(negedge clk_pin);
        rst_n_pin = 1'b1;
        repeat (2) @(negedge clk_pin);
        check("idle_led", led_pin, 16'h0000);

        run_op(8'h39, 2, 1'b0, 8'h00, 1'b0, "t1_9m3");
        run_op(8'h93, 2, 1'b0, 8'h00, 1'b0, "t2_3m9");
        run_op(8'hF0, 2, 1'b0, 8'h00, 1'b0, "t3_0m15");
        run_op(8'h55, 2, 1'b0, 8'h00, 1'b0, "t3_5m5");
        run_op(8'h2C, 20, 1'b1, 8'h11, 1'b0, "t4_hold");
        run_op(8'h7A, 5, 1'b0, 8'h00, 1'b1, "t4_repress");

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk_pin);
        sw_pin = 8'h1F;
        btn_pin = 1'b1;
        repeat (2) @(negedge clk_pin);
        btn_pin = 1'b0;
        repeat (3) @(negedge clk_pin);
        check("t5_busy_before_rst", {31'd0, led_pin[15]}, 1);
        #2 rst_n_pin = 1'b0;
        #1 check("t5_led_in_rst", led_pin, 16'h0000);
        repeat (2) @(negedge clk_pin);
        #3 rst_n_pin = 1'b1;
        repeat (3) @(negedge clk_pin);
        check("t5_idle_after_rst", led_pin, 16'h0000);
        run_op(8'hC4, 2, 1'b0, 8'h00, 1'b0, "t5_after_rst");

        begin
            int off;
            off = int'($urandom_range(0, 255));
            for (int i = 0; i < 256; i++)
                run_op(8'((i + off) % 256), 2, 1'b0, 8'h00, 1'b0, "t6_sweep");
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
